wb_fifo_slave: RTL and testbench
================================

// Module: wb_fifo_slave
//
// PURPOSE
// - Wishbone B3 slave terminating the ok2wbm master's single and burst cycles in a
//   FIFO-backed mailbox.
// - Host burst writes (BTPipeIn -> ok2wbm) push words; burst reads (BTPipeOut) pop them.
// - Sits beside wb_regmap on the shared wb_* bus and drives wb_int_o when the fill
//   level crosses a host-set threshold.
//
// PARAMETERS
// - DW          16   data width; also the wb_dat_i/wb_dat_o width.
// - AW           5   wb_adr_i width.
// - DEPTH_LOG2   4   FIFO depth is 2**DEPTH_LOG2 words (16).
//
// PORTS
// - wb_clk_i    in   1          sole clock; every register is clocked on its rising edge.
// - wb_rst_n_i  in   1          asynchronous, active-low reset.
// - wb_cyc_i    in   1          bus cycle valid.
// - wb_stb_i    in   1          strobe; a beat is requested when cyc & stb.
// - wb_we_i     in   1          1 = write, 0 = read.
// - wb_adr_i    in   AW         register address.
// - wb_sel_i    in   DW/8       byte lane selects.
// - wb_cti_i    in   3          000 classic, 010 incrementing burst, 111 end of burst.
// - wb_dat_i    in   DW         write data.
// - wb_dat_o    out  DW         read data; registered, valid while wb_ack_o is high.
// - wb_ack_o    out  1          beat acknowledge.
// - wb_err_o    out  1          beat error; mutually exclusive with wb_ack_o.
// - wb_int_o    out  1          level interrupt.
//
// BEHAVIOUR
// Register map:
// - 0x00 DATA   W: push; R: pop.
// - 0x01 STATUS RO: {8'd0, ovf, udf, full, empty, 4'd0}.
// - 0x02 CTRL   RW: [0] flush (self-clearing), [1] clear sticky flags (self-clearing),
//               [15:8] threshold.
// - 0x03 LEVEL  RO: count, zero-extended to DW.
// - Any other address: the beat terminates with wb_err_o, and there are no side effects.
//
// Handshake:
// - Classic (cti=000): ack/err rises one cycle after cyc & stb and stays high for one
//   cycle only. The next beat needs stb to be sampled again after ack drops, so there
//   are 2 cycles per beat.
// - Burst (cti=010): the first beat takes 1 cycle of latency. After that, ack stays high
//   every cycle that cyc & stb hold, for 1 beat per cycle.
// - A beat sampled with cti=111 is acked, and ack falls on the following cycle.
// - Address is not incremented internally. A burst targeting DATA pushes or pops on
//   every beat.
// - Side effects (push, pop, CTRL update) occur on the clock edge where ack_o is
//   registered high. Errored beats have no side effects.
// - Deasserting cyc mid-burst drops ack and err on the next edge. No partial state
//   is retained.
//
// FIFO:
// - Depth is 2**DEPTH_LOG2. Pointers are DEPTH_LOG2+1 bits wide; the extra MSB
//   disambiguates full from empty.
// - count = wr_ptr - rd_ptr, modulo 2**(DEPTH_LOG2+1), in the range 0..DEPTH.
// - A push requires sel == all-ones; a partial sel gives err.
// - Push when full gives err, the data is dropped and ovf is set (sticky).
// - Pop when empty gives err, wb_dat_o = 0 and udf is set (sticky).
// - Pop returns mem[rd_ptr] registered into wb_dat_o on the ack edge.
// - Pointers wrap silently.
// - Writing CTRL with flush=1 zeroes both pointers on the ack edge. The threshold in the
//   same write is still stored.
// - CTRL writes honour byte lanes: sel[0] governs bits [7:0] and sel[1] governs bits [15:8].
//
// Interrupt:
// - wb_int_o is registered: (count >= threshold) && (threshold != 0).
// - It updates one cycle after a count change.
//
// Reset (async, when wb_rst_n_i = 0):
// - ack = err = int = 0.
// - dat_o = 0.
// - Pointers = 0, flags = 0, threshold = 0.
// - FIFO memory contents are not reset.
// - A reset mid-burst aborts immediately. After reset release the slave is idle and empty.
//
// CONFIGURATION
// - WB_FIFO_SLAVE_STATS_EN defined:
//   - Adds 0x04 OVFCNT (RO) and 0x05 UDFCNT (RO): 16-bit saturating counts of errored
//     pushes and pops.
//   - Both counters clear on the CTRL[1] write and on reset.
// - Not defined:
//   - 0x04 and 0x05 are unmapped and return err.
//   - No counter logic is built.
//
// TESTING
// - Classic write 0x1234 to DATA, then a classic read of LEVEL -> ack 1 cycle after stb
//   each time, LEVEL = 1, STATUS.empty = 0.
// - 16-beat burst write (cti 010 x15, then 111) of 0..15, then a 16-beat burst read ->
//   ack held for 16 consecutive cycles; data 0..15 in order; full=1 after the writes and
//   empty=1 after the reads.
// - A 17th push when full -> err on that beat, ovf=1, LEVEL stays 16. Popping when empty
//   -> err, dat_o=0, udf=1. A CTRL write of 0x0002 clears both flags.
// - Threshold=4 via CTRL sel=10 write of 0x0400 -> wb_int_o rises 1 cycle after the 4th
//   push and falls after the next pop. A CTRL write of 0x0001 flushes: LEVEL=0, int=0.
// - Assert wb_rst_n_i low mid-burst read -> ack, err and dat_o go to 0 immediately; after
//   release LEVEL=0 and an access to 0x06 returns err.
// - STATS_EN build: 3 overflow pushes -> OVFCNT=3. Non-STATS build: a read of 0x04
//   returns err.

Source files
------------

// File: rtl/wb_fifo_slave.sv
// Wishbone B3 FIFO mailbox slave: DATA push/pop, STATUS, CTRL, LEVEL and a fill-level interrupt.
// Build option WB_FIFO_SLAVE_STATS_EN adds saturating OVFCNT (0x04) and UDFCNT (0x05) registers.
module wb_fifo_slave #(
    parameter int DW         = 16,
    parameter int AW         = 5,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    input  logic            wb_we_i,
    input  logic [AW-1:0]   wb_adr_i,
    input  logic [DW/8-1:0] wb_sel_i,
    input  logic [2:0]      wb_cti_i,
    input  logic [DW-1:0]   wb_dat_i,
    output logic [DW-1:0]   wb_dat_o,
    output logic            wb_ack_o,
    output logic            wb_err_o,
    output logic            wb_int_o
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    localparam logic [AW-1:0] ADR_DATA   = AW'(0);
    localparam logic [AW-1:0] ADR_STATUS = AW'(1);
    localparam logic [AW-1:0] ADR_CTRL   = AW'(2);
    localparam logic [AW-1:0] ADR_LEVEL  = AW'(3);
`ifdef WB_FIFO_SLAVE_STATS_EN
    localparam logic [AW-1:0] ADR_OVFCNT = AW'(4);
    localparam logic [AW-1:0] ADR_UDFCNT = AW'(5);
`endif

    // LAST: responding to a classic or end-of-burst beat, so the still-held strobe is ignored.
    // BURST: responding to an incrementing beat, so the next beat is taken on the very next edge.
    typedef enum logic [1:0] {ST_IDLE, ST_LAST, ST_BURST} state_t;
    state_t state_q, state_d;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] dat_q, dat_d;
    logic [7:0]    thr_q, thr_d;
    logic          ack_q, ack_d, err_q, err_d, int_q, int_d;
    logic          ovf_q, ovf_d, udf_q, udf_d;
`ifdef WB_FIFO_SLAVE_STATS_EN
    logic [15:0]   ovf_cnt_q, ovf_cnt_d, udf_cnt_q, udf_cnt_d;
`endif
    logic [DW-1:0] mem [DEPTH];
    logic          mem_we;
    logic [PW-1:0] count;
    logic          full, empty, beat;

    assign count = wr_ptr_q - rd_ptr_q;
    assign full  = count[DEPTH_LOG2];
    assign empty = (count == '0);
    assign beat  = wb_cyc_i && wb_stb_i && (state_q != ST_LAST);

    always_comb begin
        state_d = ST_IDLE;
        if (beat) begin
            state_d = (wb_cti_i == 3'b010) ? ST_BURST : ST_LAST;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        thr_d    = thr_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        dat_d    = '0;
        mem_we   = 1'b0;
`ifdef WB_FIFO_SLAVE_STATS_EN
        ovf_cnt_d = ovf_cnt_q;
        udf_cnt_d = udf_cnt_q;
`endif
        if (beat) begin
            ack_d = 1'b1;
            case (wb_adr_i)
                ADR_DATA: begin
                    if (wb_we_i) begin
                        if (wb_sel_i != '1) begin
                            ack_d = 1'b0;
                            err_d = 1'b1;
                        end else if (full) begin
                            ack_d = 1'b0;
                            err_d = 1'b1;
                            ovf_d = 1'b1;
`ifdef WB_FIFO_SLAVE_STATS_EN
                            if (ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
`endif
                        end else begin
                            mem_we   = 1'b1;
                            wr_ptr_d = wr_ptr_q + PW'(1);
                        end
                    end else if (empty) begin
                        ack_d = 1'b0;
                        err_d = 1'b1;
                        udf_d = 1'b1;
`ifdef WB_FIFO_SLAVE_STATS_EN
                        if (udf_cnt_q != 16'hFFFF) udf_cnt_d = udf_cnt_q + 16'd1;
`endif
                    end else begin
                        dat_d    = mem[rd_ptr_q[DEPTH_LOG2-1:0]];
                        rd_ptr_d = rd_ptr_q + PW'(1);
                    end
                end
                ADR_STATUS: if (!wb_we_i) dat_d = DW'({ovf_q, udf_q, full, empty, 4'd0});
                ADR_CTRL: begin
                    if (wb_we_i) begin
                        if (wb_sel_i[0] && wb_dat_i[0]) begin
                            wr_ptr_d = '0;
                            rd_ptr_d = '0;
                        end
                        if (wb_sel_i[0] && wb_dat_i[1]) begin
                            ovf_d = 1'b0;
                            udf_d = 1'b0;
`ifdef WB_FIFO_SLAVE_STATS_EN
                            ovf_cnt_d = '0;
                            udf_cnt_d = '0;
`endif
                        end
                        if (wb_sel_i[1]) thr_d = wb_dat_i[15:8];
                    end else begin
                        dat_d = DW'({thr_q, 8'd0});
                    end
                end
                ADR_LEVEL: if (!wb_we_i) dat_d = DW'(count);
`ifdef WB_FIFO_SLAVE_STATS_EN
                ADR_OVFCNT: if (!wb_we_i) dat_d = DW'(ovf_cnt_q);
                ADR_UDFCNT: if (!wb_we_i) dat_d = DW'(udf_cnt_q);
`endif
                default: begin
                    ack_d = 1'b0;
                    err_d = 1'b1;
                end
            endcase
        end
        int_d = (thr_q != 8'd0) && (32'(count) >= 32'(thr_q));
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            thr_q    <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            int_q    <= 1'b0;
            dat_q    <= '0;
`ifdef WB_FIFO_SLAVE_STATS_EN
            ovf_cnt_q <= '0;
            udf_cnt_q <= '0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            thr_q    <= thr_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            int_q    <= int_d;
            dat_q    <= dat_d;
`ifdef WB_FIFO_SLAVE_STATS_EN
            ovf_cnt_q <= ovf_cnt_d;
            udf_cnt_q <= udf_cnt_d;
`endif
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which words are valid.
    always_ff @(posedge wb_clk_i) begin
        if (mem_we) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= wb_dat_i;
    end

    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_int_o = int_q;
endmodule

// File: tb/tb_wb_fifo_slave.sv
// Self-checking bench for wb_fifo_slave against a queue-based mailbox model.
// Build with WB_FIFO_SLAVE_STATS_EN defined to check the error-counter registers too.
module tb_wb_fifo_slave;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic        we;
        logic [4:0]  adr;
        logic [1:0]  sel;
        logic [15:0] d;
    } access_t;

    logic        wb_clk_i   = 1'b0;
    logic        wb_rst_n_i = 1'b0;
    logic        wb_cyc_i   = 1'b0;
    logic        wb_stb_i   = 1'b0;
    logic        wb_we_i    = 1'b0;
    logic [4:0]  wb_adr_i   = '0;
    logic [1:0]  wb_sel_i   = '0;
    logic [2:0]  wb_cti_i   = '0;
    logic [15:0] wb_dat_i   = '0;
    logic [15:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o, wb_int_o;

    wb_fifo_slave dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_n_i(wb_rst_n_i),
        .wb_cyc_i  (wb_cyc_i),
        .wb_stb_i  (wb_stb_i),
        .wb_we_i   (wb_we_i),
        .wb_adr_i  (wb_adr_i),
        .wb_sel_i  (wb_sel_i),
        .wb_cti_i  (wb_cti_i),
        .wb_dat_i  (wb_dat_i),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_o  (wb_ack_o),
        .wb_err_o  (wb_err_o),
        .wb_int_o  (wb_int_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Mailbox model: a plain queue plus the sticky flags, threshold and error counts.
    logic [15:0] m_q[$];
    logic        m_ovf, m_udf;
    logic [7:0]  m_thr;
    logic [15:0] m_ovfcnt, m_udfcnt;

    // Classic access: {ack, err, rdata, int} one cycle after strobe, then {ack, err, int} a cycle later.
    logic [21:0] c_got, c_exp;
    // Burst beats: {ack, err, rdata}; burst tail one cycle after the last response: {ack, err, int}.
    logic [17:0] b_got [0:31];
    logic [17:0] b_exp [0:31];
    logic [15:0] b_din [0:31];
    logic [2:0]  bt_got, bt_exp;

    function automatic void model_reset();
        m_q.delete();
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        m_thr    = 8'd0;
        m_ovfcnt = 16'd0;
        m_udfcnt = 16'd0;
    endfunction

    function automatic logic model_int();
        return (m_thr != 8'd0) && (m_q.size() >= int'(m_thr));
    endfunction

    function automatic void predict(input logic we, input logic [4:0] adr, input logic [1:0] sel,
                                    input logic [15:0] d, output logic e_ack, output logic e_err,
                                    output logic [15:0] e_dat);
        e_ack = 1'b1;
        e_err = 1'b0;
        e_dat = 16'h0;
        case (adr)
            5'd0: begin
                if (we) begin
                    if (sel != 2'b11) begin
                        e_ack = 1'b0; e_err = 1'b1;
                    end else if (m_q.size() == DEPTH) begin
                        e_ack = 1'b0; e_err = 1'b1; m_ovf = 1'b1;
                        if (m_ovfcnt != 16'hFFFF) m_ovfcnt++;
                    end else begin
                        m_q.push_back(d);
                    end
                end else if (m_q.size() == 0) begin
                    e_ack = 1'b0; e_err = 1'b1; m_udf = 1'b1;
                    if (m_udfcnt != 16'hFFFF) m_udfcnt++;
                end else begin
                    e_dat = m_q.pop_front();
                end
            end
            5'd1: if (!we) e_dat = {8'd0, m_ovf, m_udf, m_q.size() == DEPTH, m_q.size() == 0, 4'd0};
            5'd2: begin
                if (we) begin
                    if (sel[0] && d[0]) m_q.delete();
                    if (sel[0] && d[1]) begin
                        m_ovf = 1'b0; m_udf = 1'b0; m_ovfcnt = 16'd0; m_udfcnt = 16'd0;
                    end
                    if (sel[1]) m_thr = d[15:8];
                end else begin
                    e_dat = {m_thr, 8'd0};
                end
            end
            5'd3: if (!we) e_dat = 16'(m_q.size());
`ifdef WB_FIFO_SLAVE_STATS_EN
            5'd4: if (!we) e_dat = m_ovfcnt;
            5'd5: if (!we) e_dat = m_udfcnt;
`endif
            default: begin
                e_ack = 1'b0; e_err = 1'b1;
            end
        endcase
    endfunction

    task automatic bus_idle();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_cti_i = 3'b000;
    endtask

    // Classic beat: strobe held through the response cycle, as a classic master does.
    task automatic classic(input access_t a);
        logic        e_ack, e_err, pre_int;
        logic [15:0] e_dat;
        logic [18:0] first;
        @(negedge wb_clk_i);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_cti_i = 3'b000;
        wb_we_i = a.we; wb_adr_i = a.adr; wb_sel_i = a.sel; wb_dat_i = a.d;
        pre_int = model_int();
        predict(a.we, a.adr, a.sel, a.d, e_ack, e_err, e_dat);
        @(negedge wb_clk_i);
        first = {wb_ack_o, wb_err_o, a.we ? 16'h0 : wb_dat_o, wb_int_o};
        @(negedge wb_clk_i);
        c_got = {first, wb_ack_o, wb_err_o, wb_int_o};
        c_exp = {e_ack, e_err, e_dat, pre_int, 1'b0, 1'b0, model_int()};
        bus_idle();
    endtask

    // Streaming burst on DATA: one beat per cycle; the final beat is either cti=111 held
    // for one more cycle, or (abort) an incrementing beat followed by dropping cyc.
    task automatic burst(input logic bwe, input int n, input logic abort);
        logic        e_ack, e_err;
        logic [15:0] e_dat;
        for (int i = 0; i <= n; i++) begin
            @(negedge wb_clk_i);
            if (i > 0) b_got[i-1] = {wb_ack_o, wb_err_o, bwe ? 16'h0 : wb_dat_o};
            if (i < n) begin
                wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = bwe; wb_adr_i = 5'd0;
                wb_sel_i = 2'b11; wb_dat_i = b_din[i];
                wb_cti_i = (i == n - 1 && !abort) ? 3'b111 : 3'b010;
                predict(bwe, 5'd0, 2'b11, b_din[i], e_ack, e_err, e_dat);
                b_exp[i] = {e_ack, e_err, e_dat};
            end else if (abort) begin
                bus_idle();
            end
        end
        @(negedge wb_clk_i);
        bt_got = {wb_ack_o, wb_err_o, wb_int_o};
        bt_exp = {2'b00, model_int()};
        bus_idle();
    endtask

    task automatic test_reset();
        access_t tbl [3];
        tbl = '{'{1'b0, 5'd3, 2'b11, 16'h0}, '{1'b0, 5'd1, 2'b11, 16'h0}, '{1'b0, 5'd2, 2'b11, 16'h0}};
        wb_rst_n_i = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        n_checks++;
        if ({wb_ack_o, wb_err_o, wb_int_o, wb_dat_o} !== 19'h0)
            $display("FAIL reset_outputs: got %h, expected 0", {wb_ack_o, wb_err_o, wb_int_o, wb_dat_o});
        else n_pass++;
        wb_rst_n_i = 1'b1;
        model_reset();
        for (int i = 0; i < $size(tbl); i++) begin
            classic(tbl[i]);
            n_checks++;
            if (c_got !== c_exp) $display("FAIL reset_state[%0d]: got %h, expected %h", i, c_got, c_exp);
            else n_pass++;
        end
    endtask

    task automatic test_classic();
        access_t tbl [4];
        tbl = '{'{1'b1, 5'd0, 2'b11, 16'h1234}, '{1'b0, 5'd3, 2'b11, 16'h0},
                '{1'b0, 5'd1, 2'b11, 16'h0},    '{1'b0, 5'd0, 2'b11, 16'h0}};
        for (int i = 0; i < $size(tbl); i++) begin
            classic(tbl[i]);
            n_checks++;
            if (c_got !== c_exp) $display("FAIL classic[%0d]: got %h, expected %h", i, c_got, c_exp);
            else n_pass++;
        end
    endtask

    task automatic test_burst();
        access_t st = '{1'b0, 5'd1, 2'b11, 16'h0};
        classic('{1'b1, 5'd2, 2'b11, 16'h0003});
        for (int pass = 0; pass < 4; pass++) begin
            int n = (pass < 2) ? 16 : 3;
            for (int i = 0; i < n; i++) b_din[i] = 16'(i);
            burst(pass[0] == 1'b0, n, pass >= 2);
            for (int i = 0; i < n; i++) begin
                n_checks++;
                if (b_got[i] !== b_exp[i]) $display("FAIL burst%0d_beat[%0d]: got %h, expected %h", pass, i, b_got[i], b_exp[i]);
                else n_pass++;
            end
            n_checks++;
            if (bt_got !== bt_exp) $display("FAIL burst%0d_tail: got %h, expected %h", pass, bt_got, bt_exp);
            else n_pass++;
            classic(st);
            n_checks++;
            if (c_got !== c_exp) $display("FAIL burst%0d_status: got %h, expected %h", pass, c_got, c_exp);
            else n_pass++;
        end
    endtask

    task automatic test_overflow_underflow();
        access_t tbl [9];
        tbl = '{'{1'b1, 5'd0, 2'b11, 16'hDEAD}, '{1'b0, 5'd1, 2'b11, 16'h0}, '{1'b0, 5'd3, 2'b11, 16'h0},
                '{1'b1, 5'd2, 2'b01, 16'h0001}, '{1'b1, 5'd0, 2'b01, 16'hBEEF}, '{1'b0, 5'd0, 2'b11, 16'h0},
                '{1'b0, 5'd1, 2'b11, 16'h0},    '{1'b1, 5'd2, 2'b11, 16'h0002}, '{1'b0, 5'd1, 2'b11, 16'h0}};
        classic('{1'b1, 5'd2, 2'b11, 16'h0003});
        for (int i = 0; i < DEPTH; i++) b_din[i] = 16'h0100 + 16'(i);
        burst(1'b1, DEPTH, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (b_got[i] !== b_exp[i]) $display("FAIL fill_beat[%0d]: got %h, expected %h", i, b_got[i], b_exp[i]);
            else n_pass++;
        end
        for (int i = 0; i < $size(tbl); i++) begin
            classic(tbl[i]);
            n_checks++;
            if (c_got !== c_exp) $display("FAIL ovf_udf[%0d]: got %h, expected %h", i, c_got, c_exp);
            else n_pass++;
        end
    endtask

    task automatic test_threshold_int();
        access_t tbl [13];
        tbl = '{'{1'b1, 5'd2, 2'b11, 16'h0003}, '{1'b1, 5'd2, 2'b10, 16'h0400},
                '{1'b1, 5'd0, 2'b11, 16'h0011}, '{1'b1, 5'd0, 2'b11, 16'h0012},
                '{1'b1, 5'd0, 2'b11, 16'h0013}, '{1'b1, 5'd0, 2'b11, 16'h0014},
                '{1'b0, 5'd0, 2'b11, 16'h0},    '{1'b1, 5'd0, 2'b11, 16'h0022},
                '{1'b1, 5'd2, 2'b01, 16'h0001}, '{1'b0, 5'd3, 2'b11, 16'h0},
                '{1'b0, 5'd2, 2'b11, 16'h0},    '{1'b1, 5'd2, 2'b11, 16'h0301},
                '{1'b0, 5'd2, 2'b11, 16'h0}};
        for (int i = 0; i < $size(tbl); i++) begin
            classic(tbl[i]);
            n_checks++;
            if (c_got !== c_exp) $display("FAIL threshold[%0d]: got %h, expected %h", i, c_got, c_exp);
            else n_pass++;
        end
    endtask

    task automatic test_stats();
        access_t tbl [9];
        tbl = '{'{1'b1, 5'd0, 2'b11, 16'h0AA0}, '{1'b1, 5'd0, 2'b11, 16'h0AA1}, '{1'b1, 5'd0, 2'b11, 16'h0AA2},
                '{1'b0, 5'd4, 2'b11, 16'h0},    '{1'b0, 5'd5, 2'b11, 16'h0},    '{1'b1, 5'd2, 2'b01, 16'h0001},
                '{1'b0, 5'd0, 2'b11, 16'h0},    '{1'b0, 5'd5, 2'b11, 16'h0},    '{1'b0, 5'd6, 2'b11, 16'h0}};
        classic('{1'b1, 5'd2, 2'b11, 16'h0003});
        for (int i = 0; i < DEPTH; i++) b_din[i] = 16'h0200 + 16'(i);
        burst(1'b1, DEPTH, 1'b0);
        for (int i = 0; i < $size(tbl); i++) begin
            classic(tbl[i]);
            n_checks++;
            if (c_got !== c_exp) $display("FAIL stats[%0d]: got %h, expected %h", i, c_got, c_exp);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                int  n     = int'($urandom_range(2, 8));
                logic bwe  = 1'($urandom_range(0, 1));
                logic abrt = ($urandom_range(0, 3) == 0);
                for (int i = 0; i < n; i++) b_din[i] = 16'($urandom());
                burst(bwe, n, abrt);
                for (int i = 0; i < n; i++) begin
                    n_checks++;
                    if (b_got[i] !== b_exp[i]) $display("FAIL rand%0d_beat[%0d]: got %h, expected %h", it, i, b_got[i], b_exp[i]);
                    else n_pass++;
                end
                n_checks++;
                if (bt_got !== bt_exp) $display("FAIL rand%0d_tail: got %h, expected %h", it, bt_got, bt_exp);
                else n_pass++;
            end else begin
                access_t a;
                int r = int'($urandom_range(0, 9));
                a.we  = 1'($urandom_range(0, 1));
                a.sel = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
                a.d   = 16'($urandom());
                if (r <= 4)      a.adr = 5'd0;
                else if (r == 5) a.adr = 5'd1;
                else if (r == 6) a.adr = 5'd2;
                else if (r == 7) a.adr = 5'd3;
                else if (r == 8) a.adr = 5'($urandom_range(4, 5));
                else             a.adr = 5'($urandom_range(6, 31));
                if (a.adr == 5'd2)
                    a.d = {8'($urandom_range(0, 18)), 6'd0, 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0)};
                classic(a);
                n_checks++;
                if (c_got !== c_exp) $display("FAIL rand%0d: got %h, expected %h", it, c_got, c_exp);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic        e_ack, e_err;
        logic [15:0] e_dat;
        access_t     tbl [2];
        tbl = '{'{1'b0, 5'd3, 2'b11, 16'h0}, '{1'b0, 5'd6, 2'b11, 16'h0}};
        classic('{1'b1, 5'd2, 2'b11, 16'h0003});
        for (int i = 0; i < 4; i++) b_din[i] = 16'hA5A1 + 16'(i);
        burst(1'b1, 4, 1'b0);
        @(negedge wb_clk_i);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 5'd0;
        wb_sel_i = 2'b11; wb_cti_i = 3'b010;
        predict(1'b0, 5'd0, 2'b11, 16'h0, e_ack, e_err, e_dat);
        @(negedge wb_clk_i);
        n_checks++;
        if ({wb_ack_o, wb_err_o, wb_dat_o} !== {e_ack, e_err, e_dat})
            $display("FAIL mid_burst_beat: got %h, expected %h", {wb_ack_o, wb_err_o, wb_dat_o}, {e_ack, e_err, e_dat});
        else n_pass++;
        #2 wb_rst_n_i = 1'b0;
        #1;
        n_checks++;
        if ({wb_ack_o, wb_err_o, wb_int_o, wb_dat_o} !== 19'h0)
            $display("FAIL mid_burst_reset: got %h, expected 0", {wb_ack_o, wb_err_o, wb_int_o, wb_dat_o});
        else n_pass++;
        bus_idle();
        @(negedge wb_clk_i);
        wb_rst_n_i = 1'b1;
        model_reset();
        for (int i = 0; i < $size(tbl); i++) begin
            classic(tbl[i]);
            n_checks++;
            if (c_got !== c_exp) $display("FAIL after_reset[%0d]: got %h, expected %h", i, c_got, c_exp);
            else n_pass++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_classic();
        test_burst();
        test_overflow_underflow();
        test_threshold_int();
        test_stats();
        test_random();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
